// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro: DATA_MEM_STATS_EN (request statistics counters).
package data_mem_pkg;

    // Width of one stored word and of a full two-word (PC save/restore) transfer.
    localparam int WORD_W      = 16;
    localparam int BURST_WORDS = 2;
    localparam int BUS_W       = WORD_W * BURST_WORDS;

    // Width of each statistics counter.
    localparam int STAT_W = 16;

    // Addresses strictly above this value fault by default.
    localparam logic [31:0] DEFAULT_FAULT_ADDR = 32'hFFFF_0000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        XFER0,
        XFER1,
        RESP
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the CPU memory stage (master)
// and the data-memory responder (slave).
interface data_mem_responder_if;
    import data_mem_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_wr;
    logic             req_burst;
    logic [31:0]      req_addr;
    logic [BUS_W-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [BUS_W-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_wr, req_burst, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_burst, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_array.sv
// Single-port synchronous word store; read data is registered and only
// changes on a read access, so it stays stable while a response is held.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH_W = 12
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [DEPTH_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [0:(1<<DEPTH_W)-1];
    logic [WORD_W-1:0] rdata_q;

    // Write or read one word per enabled cycle.
    // NOTE: the storage array has no reset so it maps onto plain RAM macros;
    // the read register only feeds gated outputs, so it needs none either.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                // NOTE: clocked state always uses <= so every register sees
                // pre-edge values regardless of statement order.
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the data-memory interface: accepts single and two-word
// requests, inserts WAIT_CYC wait states, faults out-of-range addresses and
// returns exactly one response per accepted request.
// Optional feature macro: DATA_MEM_STATS_EN adds rd_cnt/wr_cnt/err_cnt.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          DEPTH_W    = 12,
    parameter int          WAIT_CYC   = 1,
    parameter logic [31:0] FAULT_ADDR = DEFAULT_FAULT_ADDR
) (
    input  logic clk,
    input  logic rst,
    data_mem_responder_if.slave bus
`ifdef DATA_MEM_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_cnt,
    output logic [STAT_W-1:0] wr_cnt,
    output logic [STAT_W-1:0] err_cnt
`endif
);

    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    state_t             state_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               wr_q;
    logic               burst_q;
    logic [DEPTH_W-1:0] idx_q;
    logic [BUS_W-1:0]   wdata_q;
    logic [WORD_W-1:0]  lo_q;

    logic               fault_d;
    logic               rsp_hs;
    logic               ram_en_d;
    logic               ram_we_d;
    logic [DEPTH_W-1:0] ram_addr_d;
    logic [WORD_W-1:0]  ram_wdata_d;
    logic [WORD_W-1:0]  ram_rdata;
    logic [BUS_W-1:0]   rsp_rdata_d;

    // A two-word access at the top address would wrap the 32-bit space.
    assign fault_d = (bus.req_addr > FAULT_ADDR) ||
                     (bus.req_burst && (bus.req_addr == 32'hFFFF_FFFF));

    assign rsp_hs = (state_q == RESP) && bus.rsp_ready;

    // Steer the array from the transfer states; the second word lives one
    // index up and wraps inside the array.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        ram_en_d    = 1'b0;
        ram_we_d    = wr_q;
        ram_addr_d  = idx_q;
        ram_wdata_d = wdata_q[WORD_W-1:0];
        if (state_q == XFER0) begin
            ram_en_d = 1'b1;
        end else if (state_q == XFER1) begin
            ram_en_d    = 1'b1;
            ram_addr_d  = idx_q + DEPTH_W'(1);
            ram_wdata_d = wdata_q[BUS_W-1:WORD_W];
        end
    end

    // Read data is returned only for successful reads while responding.
    always_comb begin
        rsp_rdata_d = '0;
        if ((state_q == RESP) && !wr_q && !rsp_err_q) begin
            if (burst_q) begin
                rsp_rdata_d = {ram_rdata, lo_q};
            end else begin
                rsp_rdata_d = {{(BUS_W-WORD_W){1'b0}}, ram_rdata};
            end
        end
    end

    // Request-to-response sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
            wr_q        <= 1'b0;
            burst_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q        <= bus.req_wr;
                        burst_q     <= bus.req_burst;
                        idx_q       <= bus.req_addr[DEPTH_W-1:0];
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (fault_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (WAIT_CYC > 0) begin
                            state_q <= WAIT;
                        end else begin
                            state_q <= XFER0;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == CNT_W'(WAIT_CYC - 1)) begin
                        wait_cnt_q <= '0;
                        state_q    <= XFER0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                XFER0: begin
                    if (burst_q) begin
                        state_q <= XFER1;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                XFER1: begin
                    // The first word's read data is about to be overwritten.
                    lo_q        <= ram_rdata;
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_d;

    data_mem_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en_d),
        .we_i    (ram_we_d),
        .addr_i  (ram_addr_d),
        .wdata_i (ram_wdata_d),
        .rdata_o (ram_rdata)
    );

`ifdef DATA_MEM_STATS_EN
    logic [STAT_W-1:0] rd_cnt_q;
    logic [STAT_W-1:0] wr_cnt_q;
    logic [STAT_W-1:0] err_cnt_q;

    // Count each completed response once, classified by outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (rsp_hs) begin
            if (rsp_err_q) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end else if (wr_q) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end else begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    // Handshake qualifier is only consumed by the statistics counters.
    logic unused_rsp_hs;
    assign unused_rsp_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: each request's expected response
// is computed from a word-array model when it is issued and compared when
// the DUT raises rsp_valid.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    localparam int          DEPTH_W    = 12;
    localparam int          WAIT_CYC   = 1;
    localparam logic [31:0] FAULT_ADDR = 32'hFFFF_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_mem_responder_if bus ();

`ifdef DATA_MEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt;
`endif

    data_mem_responder #(
        .DEPTH_W    (DEPTH_W),
        .WAIT_CYC   (WAIT_CYC),
        .FAULT_ADDR (FAULT_ADDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DATA_MEM_STATS_EN
        ,
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt),
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t        sb_q [$];
    logic [15:0] model_mem [0:(1<<DEPTH_W)-1];
    int          checks   = 0;
    int          failures = 0;
    int          exp_rd   = 0;
    int          exp_wr   = 0;
    int          exp_err  = 0;

    // Reference behaviour: fault rule, word placement, wait-state latency
    // counted in edges after the accepting edge (a fault responds on it).
    function automatic exp_t model_req(input logic wr, input logic burst,
                                       input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic [DEPTH_W-1:0] i0, i1;
        i0      = addr[DEPTH_W-1:0];
        i1      = i0 + DEPTH_W'(1);
        e.rdata = '0;
        e.err   = 1'b0;
        e.lat   = WAIT_CYC + (burst ? 2 : 1);
        if ((addr > FAULT_ADDR) || (burst && (addr == 32'hFFFF_FFFF))) begin
            e.err = 1'b1;
            e.lat = 0;
        end else if (wr) begin
            model_mem[i0] = wdata[15:0];
            if (burst) model_mem[i1] = wdata[31:16];
        end else begin
            e.rdata[15:0] = model_mem[i0];
            if (burst) e.rdata[31:16] = model_mem[i1];
        end
        return e;
    endfunction

    // Issue one request, wait for its response, optionally stall it for
    // 'hold' cycles while a bogus request is presented, then accept it.
    task automatic run_req(input logic wr, input logic burst, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold, input string name);
        exp_t e;
        int   lat;
        sb_q.push_back(model_req(wr, burst, addr, wdata));
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_idle got=%b exp=1", name, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_burst = burst;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_busy got=%b exp=0", name, bus.req_ready);
        end
        lat = 0;
        while ((bus.rsp_valid !== 1'b1) && (lat < 64)) begin
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout got=no_rsp exp=rsp_valid", name);
            return;
        end
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, lat, e.lat);
        end
        checks++;
        if (bus.rsp_rdata !== e.rdata) begin
            failures++;
            $display("FAIL %s_rdata got=%h exp=%h", name, bus.rsp_rdata, e.rdata);
        end
        checks++;
        if (bus.rsp_err !== e.err) begin
            failures++;
            $display("FAIL %s_err got=%b exp=%b", name, bus.rsp_err, e.err);
        end
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_wr    = 1'b1;
            bus.req_burst = 1'b0;
            bus.req_addr  = 32'h10;
            bus.req_wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            checks++;
            if ((bus.rsp_valid !== 1'b1) || (bus.rsp_rdata !== e.rdata) || (bus.req_ready !== 1'b0)) begin
                failures++;
                $display("FAIL %s_hold%0d got=v%b/%h/r%b exp=v1/%h/r0",
                         name, i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, e.rdata);
            end
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        if (e.err) exp_err++;
        else if (wr) exp_wr++;
        else exp_rd++;
        checks++;
        if ((bus.rsp_valid !== 1'b0) || (bus.req_ready !== 1'b1) || (bus.rsp_err !== 1'b0)) begin
            failures++;
            $display("FAIL %s_turnaround got=v%b/r%b/e%b exp=v0/r1/e0",
                     name, bus.rsp_valid, bus.req_ready, bus.rsp_err);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ((bus.req_ready !== 1'b1) || (bus.rsp_valid !== 1'b0) ||
            (bus.rsp_err !== 1'b0) || (bus.rsp_rdata !== 32'h0)) begin
            failures++;
            $display("FAIL %s got=r%b/v%b/e%b/%h exp=r1/v0/e0/00000000",
                     name, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
`ifdef DATA_MEM_STATS_EN
        checks++;
        if ((rd_cnt !== 16'h0) || (wr_cnt !== 16'h0) || (err_cnt !== 16'h0)) begin
            failures++;
            $display("FAIL %s_stats got=%h/%h/%h exp=0/0/0", name, rd_cnt, wr_cnt, err_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_single();
        run_req(1'b1, 1'b0, 32'h10, 32'h0000_BEEF, 0, "single_wr");
        run_req(1'b0, 1'b0, 32'h10, 32'h0, 0, "single_rd");
    endtask

    task automatic test_burst();
        run_req(1'b1, 1'b1, 32'h20, 32'h1234_5678, 0, "burst_wr");
        run_req(1'b0, 1'b1, 32'h20, 32'h0, 0, "burst_rd");
        run_req(1'b0, 1'b0, 32'h20, 32'h0, 0, "burst_lo");
        run_req(1'b0, 1'b0, 32'h21, 32'h0, 0, "burst_hi");
    endtask

    task automatic test_fault();
        run_req(1'b1, 1'b0, 32'h1, 32'h0000_1111, 0, "pre_wr");
        run_req(1'b0, 1'b0, 32'hFFFF_0001, 32'h0, 0, "fault_rd");
        run_req(1'b1, 1'b0, 32'hFFFF_0001, 32'h0000_2222, 0, "fault_wr");
        run_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 0, "fault_wrap");
        run_req(1'b0, 1'b0, 32'h1, 32'h0, 0, "fault_noacc");
        run_req(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_7777, 0, "bound_wr");
        run_req(1'b0, 1'b0, 32'hFFFF_0000, 32'h0, 0, "bound_rd");
    endtask

    task automatic test_hold();
        run_req(1'b0, 1'b0, 32'h10, 32'h0, 5, "hold_rd");
        run_req(1'b0, 1'b0, 32'h10, 32'h0, 0, "hold_ignored");
    endtask

    task automatic test_wrap();
        run_req(1'b1, 1'b1, 32'((1 << DEPTH_W) - 1), 32'hCAFE_0BAD, 0, "wrap_wr");
        run_req(1'b0, 1'b0, 32'((1 << DEPTH_W) - 1), 32'h0, 0, "wrap_top");
        run_req(1'b0, 1'b0, 32'h0, 32'h0, 0, "wrap_zero");
    endtask

    task automatic test_reset_abort();
        logic rose;
        run_req(1'b1, 1'b0, 32'h30, 32'h0000_A5A5, 0, "abort_pre");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_burst = 1'b0;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'h0000_DEAD;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_accept got=%b exp=0", bus.req_ready);
        end
        rst = 1'b1;
        #1;
        exp_rd  = 0;
        exp_wr  = 0;
        exp_err = 0;
        check_reset_outputs("abort_reset");
        @(negedge clk);
        rst  = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_rsp got=rsp_valid exp=quiet");
        end
        run_req(1'b0, 1'b0, 32'h30, 32'h0, 0, "abort_unchanged");
    endtask

    task automatic test_stats();
`ifdef DATA_MEM_STATS_EN
        run_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 0, "stats_err");
        run_req(1'b1, 1'b1, 32'h40, 32'h5555_AAAA, 0, "stats_wr");
        checks++;
        if ((rd_cnt !== 16'(exp_rd)) || (wr_cnt !== 16'(exp_wr)) || (err_cnt !== 16'(exp_err))) begin
            failures++;
            $display("FAIL stats_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     rd_cnt, wr_cnt, err_cnt, exp_rd, exp_wr, exp_err);
        end
`endif
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_burst = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_fault();
        test_hold();
        test_wrap();
        test_reset_abort();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
